// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order commit buffer between issue/execute and
// the register file. Entries are allocated at the tail on issue, filled from
// the CDB out of order, and retired from the head in program order, at most
// one per cycle. A mispredicted branch that reaches commit flushes the whole
// buffer and raises clrOut for one cycle with the redirect PC on clrPc.
//
// Ports
//   clkIn, rstIn          clock (rising edge), async active-low reset
//   rdyIn                 global ready; low freezes all state and outputs
//   issue*                allocation request, destination, branch info
//   issueReady/issueROB   space available / tag to be allocated (= tail)
//   cdb*                  result broadcast: tag, data, branch outcome/target
//   q1*/q2*               operand lookups by tag, with same-cycle CDB bypass
//   write*                registered register-file commit port
//   clrOut/clrPc          registered mispredict flush pulse and redirect PC
module reorder_buffer #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clkIn,
    input  logic                 rstIn,
    input  logic                 rdyIn,
    input  logic                 issueValid,
    output logic                 issueReady,
    input  logic [REG_WIDTH-1:0] issueDest,
    input  logic                 issueIsBranch,
    input  logic                 issuePredTaken,
    output logic [ROB_WIDTH-1:0] issueROB,
    input  logic                 cdbValid,
    input  logic [ROB_WIDTH-1:0] cdbROB,
    input  logic [31:0]          cdbData,
    input  logic                 cdbTaken,
    input  logic [31:0]          cdbTarget,
    input  logic [ROB_WIDTH-1:0] q1ROB,
    output logic                 q1Ready,
    output logic [31:0]          q1Data,
    input  logic [ROB_WIDTH-1:0] q2ROB,
    output logic                 q2Ready,
    output logic [31:0]          q2Data,
    output logic                 writeFlag,
    output logic [ROB_WIDTH-1:0] writeSrc,
    output logic [REG_WIDTH-1:0] writeReg,
    output logic [31:0]          writeData,
    output logic                 clrOut,
    output logic [31:0]          clrPc
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0]   FULL_COUNT = {1'b1, {ROB_WIDTH{1'b0}}};
    localparam logic [ROB_WIDTH:0]   CNT_ONE    = (ROB_WIDTH+1)'(1);
    localparam logic [ROB_WIDTH-1:0] PTR_ONE    = ROB_WIDTH'(1);

    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     ready;
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;

    // Payload fields carry no reset: valid/ready gate every use of them.
    logic                 is_branch_q  [DEPTH];
    logic                 pred_taken_q [DEPTH];
    logic                 taken_q      [DEPTH];
    logic [REG_WIDTH-1:0] dest_q       [DEPTH];
    logic [31:0]          data_q       [DEPTH];
    logic [31:0]          target_q     [DEPTH];

    logic issue_fire;
    logic cdb_fire;
    logic commit_fire;
    logic mispredict;
    logic q1_hit;
    logic q2_hit;

    assign issueReady  = (count != FULL_COUNT) && !clrOut;
    assign issueROB    = tail;
    assign issue_fire  = issueValid && issueReady && rdyIn;
    // The cycle after a flush ignores the CDB: results belong to squashed work.
    assign cdb_fire    = cdbValid && rdyIn && valid[cdbROB] && !clrOut;
    assign commit_fire = (count != '0) && ready[head] && rdyIn;
    assign mispredict  = commit_fire && is_branch_q[head] &&
                         (taken_q[head] != pred_taken_q[head]);

    assign q1_hit  = cdbValid && (cdbROB == q1ROB) && valid[q1ROB];
    assign q2_hit  = cdbValid && (cdbROB == q2ROB) && valid[q2ROB];
    assign q1Ready = (valid[q1ROB] && ready[q1ROB]) || q1_hit;
    assign q2Ready = (valid[q2ROB] && ready[q2ROB]) || q2_hit;
    assign q1Data  = q1_hit ? cdbData : data_q[q1ROB];
    assign q2Data  = q2_hit ? cdbData : data_q[q2ROB];

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            valid     <= '0;
            ready     <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            writeFlag <= 1'b0;
            writeSrc  <= '0;
            writeReg  <= '0;
            writeData <= '0;
            clrOut    <= 1'b0;
            clrPc     <= '0;
        end else if (rdyIn) begin
            writeFlag <= commit_fire && !is_branch_q[head];
            clrOut    <= mispredict;
            if (commit_fire) begin
                writeSrc  <= head;
                writeReg  <= dest_q[head];
                writeData <= data_q[head];
            end
            if (mispredict) begin
                clrPc <= target_q[head];
                valid <= '0;
                ready <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (cdb_fire)
                    ready[cdbROB] <= 1'b1;
                // Commit clears after the CDB write so a late result to the
                // retiring head cannot resurrect it.
                if (commit_fire) begin
                    valid[head] <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + PTR_ONE;
                end
                if (issue_fire) begin
                    valid[tail] <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + PTR_ONE;
                end
                case ({issue_fire, commit_fire})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (rdyIn && !mispredict) begin
            if (issue_fire) begin
                dest_q[tail]       <= issueDest;
                is_branch_q[tail]  <= issueIsBranch;
                pred_taken_q[tail] <= issuePredTaken;
            end
            if (cdb_fire) begin
                data_q[cdbROB]   <= cdbData;
                taken_q[cdbROB]  <= cdbTaken;
                target_q[cdbROB] <= cdbTarget;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer. Inputs change 1 time unit after the
// rising edge; outputs are sampled there or after a further settle delay.
module tb_reorder_buffer;

    logic        clkIn = 1'b0;
    logic        rstIn = 1'b0;
    logic        rdyIn;
    logic        issueValid;
    logic        issueReady;
    logic [4:0]  issueDest;
    logic        issueIsBranch;
    logic        issuePredTaken;
    logic [3:0]  issueROB;
    logic        cdbValid;
    logic [3:0]  cdbROB;
    logic [31:0] cdbData;
    logic        cdbTaken;
    logic [31:0] cdbTarget;
    logic [3:0]  q1ROB;
    logic        q1Ready;
    logic [31:0] q1Data;
    logic [3:0]  q2ROB;
    logic        q2Ready;
    logic [31:0] q2Data;
    logic        writeFlag;
    logic [3:0]  writeSrc;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        clrOut;
    logic [31:0] clrPc;

    int n_cmp = 0;
    int n_err = 0;

    reorder_buffer #(.ROB_WIDTH(4), .REG_WIDTH(5)) dut (
        .clkIn(clkIn), .rstIn(rstIn), .rdyIn(rdyIn),
        .issueValid(issueValid), .issueReady(issueReady), .issueDest(issueDest),
        .issueIsBranch(issueIsBranch), .issuePredTaken(issuePredTaken),
        .issueROB(issueROB),
        .cdbValid(cdbValid), .cdbROB(cdbROB), .cdbData(cdbData),
        .cdbTaken(cdbTaken), .cdbTarget(cdbTarget),
        .q1ROB(q1ROB), .q1Ready(q1Ready), .q1Data(q1Data),
        .q2ROB(q2ROB), .q2Ready(q2Ready), .q2Data(q2Data),
        .writeFlag(writeFlag), .writeSrc(writeSrc), .writeReg(writeReg),
        .writeData(writeData), .clrOut(clrOut), .clrPc(clrPc)
    );

    always #5 clkIn = ~clkIn;

    task automatic idle();
        issueValid = 0; issueDest = '0; issueIsBranch = 0; issuePredTaken = 0;
        cdbValid = 0; cdbROB = '0; cdbData = '0; cdbTaken = 0; cdbTarget = '0;
        q1ROB = '0; q2ROB = '0;
    endtask

    task automatic step();
        @(posedge clkIn);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rdyIn = 1;
        rstIn = 0;
        #2;
        rstIn = 1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic br, input logic pt);
        issueValid = 1; issueDest = rd; issueIsBranch = br; issuePredTaken = pt;
        step();
        issueValid = 0;
    endtask

    task automatic do_cdb(input logic [3:0] tag, input logic [31:0] d,
                          input logic tk, input logic [31:0] tgt);
        cdbValid = 1; cdbROB = tag; cdbData = d; cdbTaken = tk; cdbTarget = tgt;
        step();
        cdbValid = 0;
    endtask

    task automatic test_reset();
        idle();
        rdyIn = 1;
        rstIn = 0;
        #2;
        n_cmp++; if (issueReady !== 1'b1) begin n_err++; $display("FAIL reset_issueReady: got %0h want 1", issueReady); end
        n_cmp++; if (issueROB !== 4'd0) begin n_err++; $display("FAIL reset_issueROB: got %0d want 0", issueROB); end
        n_cmp++; if (writeFlag !== 1'b0) begin n_err++; $display("FAIL reset_writeFlag: got %0h want 0", writeFlag); end
        n_cmp++; if (writeData !== 32'h0) begin n_err++; $display("FAIL reset_writeData: got %0h want 0", writeData); end
        n_cmp++; if (clrOut !== 1'b0) begin n_err++; $display("FAIL reset_clrOut: got %0h want 0", clrOut); end
        n_cmp++; if (clrPc !== 32'h0) begin n_err++; $display("FAIL reset_clrPc: got %0h want 0", clrPc); end
        n_cmp++; if (q1Ready !== 1'b0) begin n_err++; $display("FAIL reset_q1Ready: got %0h want 0", q1Ready); end
        rstIn = 1;
        step();
        n_cmp++; if (writeFlag !== 1'b0) begin n_err++; $display("FAIL reset_empty_noCommit: got %0h want 0", writeFlag); end
    endtask

    task automatic test_basic();
        apply_reset();
        n_cmp++; if (issueROB !== 4'd0) begin n_err++; $display("FAIL basic_tag0: got %0d want 0", issueROB); end
        do_issue(5'd3, 0, 0);
        n_cmp++; if (issueROB !== 4'd1) begin n_err++; $display("FAIL basic_tag1: got %0d want 1", issueROB); end
        do_issue(5'd5, 0, 0);
        n_cmp++; if (issueROB !== 4'd2) begin n_err++; $display("FAIL basic_tail2: got %0d want 2", issueROB); end
        do_cdb(4'd0, 32'h11, 0, 32'h0);
        n_cmp++; if (writeFlag !== 1'b0) begin n_err++; $display("FAIL basic_no_bypass: got %0h want 0", writeFlag); end
        step();
        n_cmp++; if (writeFlag !== 1'b1) begin n_err++; $display("FAIL basic_wflag: got %0h want 1", writeFlag); end
        n_cmp++; if (writeReg !== 5'd3) begin n_err++; $display("FAIL basic_wreg: got %0d want 3", writeReg); end
        n_cmp++; if (writeData !== 32'h11) begin n_err++; $display("FAIL basic_wdata: got %0h want 11", writeData); end
        n_cmp++; if (writeSrc !== 4'd0) begin n_err++; $display("FAIL basic_wsrc: got %0d want 0", writeSrc); end
        step();
        n_cmp++; if (writeFlag !== 1'b0) begin n_err++; $display("FAIL basic_wflag_drop: got %0h want 0", writeFlag); end
        do_cdb(4'd1, 32'h22, 0, 32'h0);
        step();
        n_cmp++; if (writeSrc !== 4'd1 || writeData !== 32'h22 || writeFlag !== 1'b1) begin
            n_err++; $display("FAIL basic_second: got src %0d data %0h flag %0h want 1 22 1", writeSrc, writeData, writeFlag); end
        step();
        n_cmp++; if (writeFlag !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %0h want 0", writeFlag); end
    endtask

    task automatic test_out_of_order();
        apply_reset();
        do_issue(5'd1, 0, 0);
        do_issue(5'd2, 0, 0);
        do_issue(5'd3, 0, 0);
        do_cdb(4'd2, 32'hC2, 0, 32'h0);
        n_cmp++; if (writeFlag !== 1'b0) begin n_err++; $display("FAIL ooo_wait2: got %0h want 0", writeFlag); end
        do_cdb(4'd1, 32'hC1, 0, 32'h0);
        n_cmp++; if (writeFlag !== 1'b0) begin n_err++; $display("FAIL ooo_wait1: got %0h want 0", writeFlag); end
        do_cdb(4'd0, 32'hC0, 0, 32'h0);
        n_cmp++; if (writeFlag !== 1'b0) begin n_err++; $display("FAIL ooo_wait0: got %0h want 0", writeFlag); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (writeFlag !== 1'b1 || writeSrc !== 4'(k) || writeReg !== 5'(k + 1) || writeData !== 32'hC0 + 32'(k)) begin
                n_err++;
                $display("FAIL ooo_commit%0d: got flag %0h src %0d reg %0d data %0h want 1 %0d %0d %0h",
                         k, writeFlag, writeSrc, writeReg, writeData, k, k + 1, 32'hC0 + 32'(k));
            end
        end
        step();
        n_cmp++; if (writeFlag !== 1'b0) begin n_err++; $display("FAIL ooo_drained: got %0h want 0", writeFlag); end
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (issueROB !== 4'(i)) begin n_err++; $display("FAIL fill_tag%0d: got %0d want %0d", i, issueROB, i); end
            do_issue(5'(i), 0, 0);
        end
        n_cmp++; if (issueReady !== 1'b0) begin n_err++; $display("FAIL full_ready: got %0h want 0", issueReady); end
        n_cmp++; if (issueROB !== 4'd0) begin n_err++; $display("FAIL full_tail_wrap: got %0d want 0", issueROB); end
        do_issue(5'd20, 0, 0);
        n_cmp++; if (issueReady !== 1'b0 || issueROB !== 4'd0) begin
            n_err++; $display("FAIL full_blocked: got ready %0h tag %0d want 0 0", issueReady, issueROB); end
        do_cdb(4'd0, 32'h55, 0, 32'h0);
        n_cmp++; if (issueReady !== 1'b0) begin n_err++; $display("FAIL full_commit_cycle_ready: got %0h want 0", issueReady); end
        step();
        n_cmp++; if (writeFlag !== 1'b1 || writeSrc !== 4'd0 || writeReg !== 5'd0 || writeData !== 32'h55) begin
            n_err++; $display("FAIL full_commit: got flag %0h src %0d reg %0d data %0h want 1 0 0 55", writeFlag, writeSrc, writeReg, writeData); end
        n_cmp++; if (issueReady !== 1'b1 || issueROB !== 4'd0) begin
            n_err++; $display("FAIL wrap_ready: got ready %0h tag %0d want 1 0", issueReady, issueROB); end
        do_issue(5'd21, 0, 0);
        n_cmp++; if (issueROB !== 4'd1 || issueReady !== 1'b0) begin
            n_err++; $display("FAIL wrap_refull: got tag %0d ready %0h want 1 0", issueROB, issueReady); end
    endtask

    task automatic test_mispredict();
        apply_reset();
        do_issue(5'd0, 1, 0);
        do_issue(5'd7, 0, 0);
        do_cdb(4'd0, 32'h0, 1, 32'h1000);
        issueValid = 1; issueDest = 5'd9;
        step();
        issueValid = 0;
        n_cmp++; if (clrOut !== 1'b1) begin n_err++; $display("FAIL mp_clrOut: got %0h want 1", clrOut); end
        n_cmp++; if (clrPc !== 32'h1000) begin n_err++; $display("FAIL mp_clrPc: got %0h want 1000", clrPc); end
        n_cmp++; if (writeFlag !== 1'b0) begin n_err++; $display("FAIL mp_writeFlag: got %0h want 0", writeFlag); end
        n_cmp++; if (issueReady !== 1'b0) begin n_err++; $display("FAIL mp_issueReady: got %0h want 0", issueReady); end
        n_cmp++; if (issueROB !== 4'd0) begin n_err++; $display("FAIL mp_issue_dropped: got %0d want 0", issueROB); end
        q1ROB = 4'd1; cdbValid = 1; cdbROB = 4'd1; cdbData = 32'h77;
        #1;
        n_cmp++; if (q1Ready !== 1'b0) begin n_err++; $display("FAIL mp_flushed_query: got %0h want 0", q1Ready); end
        step();
        cdbValid = 0;
        #1;
        n_cmp++; if (clrOut !== 1'b0 || issueReady !== 1'b1 || issueROB !== 4'd0) begin
            n_err++; $display("FAIL mp_after: got clr %0h ready %0h tag %0d want 0 1 0", clrOut, issueReady, issueROB); end
        n_cmp++; if (q1Ready !== 1'b0) begin n_err++; $display("FAIL mp_cdb_ignored: got %0h want 0", q1Ready); end
        do_issue(5'd0, 1, 1);
        do_cdb(4'd0, 32'h0, 1, 32'h2000);
        step();
        n_cmp++; if (clrOut !== 1'b0 || writeFlag !== 1'b0 || issueROB !== 4'd1) begin
            n_err++; $display("FAIL br_correct: got clr %0h flag %0h tag %0d want 0 0 1", clrOut, writeFlag, issueROB); end
        n_cmp++; if (clrPc !== 32'h1000) begin n_err++; $display("FAIL br_correct_clrPc_hold: got %0h want 1000", clrPc); end
    endtask

    task automatic test_query();
        apply_reset();
        do_issue(5'd1, 0, 0);
        do_issue(5'd2, 0, 0);
        do_issue(5'd3, 0, 0);
        q1ROB = 4'd2; q2ROB = 4'd5;
        #1;
        n_cmp++; if (q1Ready !== 1'b0) begin n_err++; $display("FAIL q_pending: got %0h want 0", q1Ready); end
        cdbValid = 1; cdbROB = 4'd2; cdbData = 32'hAB;
        #1;
        n_cmp++; if (q1Ready !== 1'b1 || q1Data !== 32'hAB) begin
            n_err++; $display("FAIL q_bypass: got ready %0h data %0h want 1 ab", q1Ready, q1Data); end
        n_cmp++; if (q2Ready !== 1'b0) begin n_err++; $display("FAIL q_unissued: got %0h want 0", q2Ready); end
        step();
        cdbValid = 0;
        q2ROB = 4'd2;
        #1;
        n_cmp++; if (q1Ready !== 1'b1 || q1Data !== 32'hAB) begin
            n_err++; $display("FAIL q_stored: got ready %0h data %0h want 1 ab", q1Ready, q1Data); end
        n_cmp++; if (q2Ready !== 1'b1 || q2Data !== 32'hAB) begin
            n_err++; $display("FAIL q2_stored: got ready %0h data %0h want 1 ab", q2Ready, q2Data); end
        q2ROB = 4'd5; cdbValid = 1; cdbROB = 4'd5; cdbData = 32'hEE;
        #1;
        n_cmp++; if (q2Ready !== 1'b0) begin n_err++; $display("FAIL q_cdb_invalid: got %0h want 0", q2Ready); end
        step();
        cdbValid = 0;
    endtask

    task automatic test_hold_and_async_reset();
        apply_reset();
        do_issue(5'd9, 0, 0);
        do_cdb(4'd0, 32'h99, 0, 32'h0);
        rdyIn = 0;
        issueValid = 1; issueDest = 5'd4;
        cdbValid = 1; cdbROB = 4'd0; cdbData = 32'h33;
        step();
        step();
        n_cmp++; if (writeFlag !== 1'b0 || issueROB !== 4'd1) begin
            n_err++; $display("FAIL hold_frozen: got flag %0h tag %0d want 0 1", writeFlag, issueROB); end
        idle();
        rdyIn = 1;
        step();
        n_cmp++; if (writeFlag !== 1'b1 || writeReg !== 5'd9 || writeData !== 32'h99) begin
            n_err++; $display("FAIL hold_release_commit: got flag %0h reg %0d data %0h want 1 9 99", writeFlag, writeReg, writeData); end
        rdyIn = 0;
        step();
        n_cmp++; if (writeFlag !== 1'b1 || writeData !== 32'h99) begin
            n_err++; $display("FAIL hold_outputs: got flag %0h data %0h want 1 99", writeFlag, writeData); end
        rdyIn = 1;
        #1;
        rstIn = 0;
        #1;
        n_cmp++; if (writeFlag !== 1'b0 || writeData !== 32'h0 || writeReg !== 5'd0 || issueROB !== 4'd0) begin
            n_err++; $display("FAIL async_reset: got flag %0h data %0h reg %0d tag %0d want 0 0 0 0", writeFlag, writeData, writeReg, issueROB); end
        step();
        rstIn = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_order();
        test_full_wrap();
        test_mispredict();
        test_query();
        test_hold_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
